// File: rtl/sha256_cfu_pkg.sv
// sha256_cfu_pkg: shared types and constants for the SHA-256 CFU unit.
//   func_e   - function select encoding (values 4..7 are illegal)
//   resp_t   - buffered response entry {id, data, error}
//   rotr32   - 32-bit rotate-right helper
//   *_R*/_S* - rotate/shift amounts (consumed only by sha256_sigma)
package sha256_cfu_pkg;

    typedef enum logic [2:0] {
        FN_SUM0 = 3'd0,
        FN_SUM1 = 3'd1,
        FN_SIG0 = 3'd2,
        FN_SIG1 = 3'd3
    } func_e;

    localparam int SUM0_R0 = 2;
    localparam int SUM0_R1 = 13;
    localparam int SUM0_R2 = 22;
    localparam int SUM1_R0 = 6;
    localparam int SUM1_R1 = 11;
    localparam int SUM1_R2 = 25;
    localparam int SIG0_R0 = 7;
    localparam int SIG0_R1 = 18;
    localparam int SIG0_S  = 3;
    localparam int SIG1_R0 = 17;
    localparam int SIG1_R1 = 19;
    localparam int SIG1_S  = 10;

    // Widest tag the response entry can carry; the top slices it to ID_W.
    localparam int ID_W_MAX = 16;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [31:0]         data;
        logic                error;
    } resp_t;

    function automatic logic [31:0] rotr32(input logic [31:0] v, input int unsigned n);
        return (v >> n) | (v << (32 - n));
    endfunction

endpackage

// File: rtl/sha256_sigma.sv
// sha256_sigma: combinational SHA-256 rotate/XOR function block.
//   x       in  32  operand
//   func    in  3   function select (func_e; 4..7 illegal)
//   result  out 32  function value, 0 for an illegal select
//   illegal out 1   select is not one of the four functions
module sha256_sigma
    import sha256_cfu_pkg::*;
(
    input  logic [31:0] x,
    input  logic [2:0]  func,
    output logic [31:0] result,
    output logic        illegal
);

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (func)
            FN_SUM0: result = rotr32(x, SUM0_R0) ^ rotr32(x, SUM0_R1) ^ rotr32(x, SUM0_R2);
            FN_SUM1: result = rotr32(x, SUM1_R0) ^ rotr32(x, SUM1_R1) ^ rotr32(x, SUM1_R2);
            FN_SIG0: result = rotr32(x, SIG0_R0) ^ rotr32(x, SIG0_R1) ^ (x >> SIG0_S);
            FN_SIG1: result = rotr32(x, SIG1_R0) ^ rotr32(x, SIG1_R1) ^ (x >> SIG1_S);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/sha256_cfu_unit.sv
// sha256_cfu_unit: pipelined SHA-256 custom-function unit.
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_id, req_func, req_data0   request tag, function select, operand
//   resp_valid/resp_ready         response handshake
//   resp_id, resp_data, resp_error  head-of-buffer response
// One register stage (S1) feeds the function block, whose result is pushed
// into a DEPTH-entry FIFO. req_ready is credit based so S1 never stalls and
// the FIFO never overflows.
module sha256_cfu_unit
    import sha256_cfu_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [ID_W-1:0] req_id,
    input  logic [2:0]      req_func,
    input  logic [31:0]     req_data0,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [ID_W-1:0] resp_id,
    output logic [31:0]     resp_data,
    output logic            resp_error
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // S1 register stage
    logic            s1_valid;
    logic [ID_W-1:0] s1_id;
    logic [2:0]      s1_func;
    logic [31:0]     s1_x;

    // response FIFO
    resp_t           mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    resp_t           head;

    logic [31:0]     sig_result;
    logic            sig_illegal;
    logic            req_fire, resp_fire;
    logic [CW:0]     credit_used;
    logic            unused_id_bits;

    sha256_sigma u_sigma (
        .x       (s1_x),
        .func    (s1_func),
        .result  (sig_result),
        .illegal (sig_illegal)
    );

    assign resp_valid = (count != '0);
    assign resp_fire  = resp_valid & resp_ready;
    assign req_fire   = req_valid & req_ready;

    // Slots committed next cycle: buffered + the one in S1, minus the one
    // leaving now. resp_fire implies count >= 1, so this cannot underflow.
    assign credit_used = {1'b0, count} + (CW+1)'(s1_valid) - (CW+1)'(resp_fire);
    assign req_ready   = credit_used < (CW+1)'(DEPTH);

    assign head       = mem[rd_ptr];
    assign resp_id    = head.id[ID_W-1:0];
    assign resp_data  = head.data;
    assign resp_error = head.error;
    assign unused_id_bits = ^head.id;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_func  <= '0;
            s1_x     <= '0;
        end else begin
            s1_valid <= req_fire;
            if (req_fire) begin
                s1_id   <= req_id;
                s1_func <= req_func;
                s1_x    <= req_data0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            // Cleared so the head outputs are defined (zero) while empty.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (s1_valid) begin
                mem[wr_ptr] <= '{id: ID_W_MAX'(s1_id), data: sig_result, error: sig_illegal};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (resp_fire) rd_ptr <= rd_ptr + PW'(1);
            case ({s1_valid, resp_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_cfu_unit.sv
module tb_sha256_cfu_unit;
    localparam int ID_W  = 4;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_ready;
    logic [ID_W-1:0] req_id;
    logic [2:0]      req_func;
    logic [31:0]     req_data0;
    logic            resp_valid, resp_ready;
    logic [ID_W-1:0] resp_id;
    logic [31:0]     resp_data;
    logic            resp_error;

    sha256_cfu_unit #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_func(req_func), .req_data0(req_data0),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_error(resp_error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // transaction-level model: accepted requests still owed a response
    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic            err;
        int              acc;
    } exp_t;
    exp_t q[$];

    logic            s_rqr, s_rv, s_re, last_fire;
    logic [ID_W-1:0] s_rid;
    logic [31:0]     s_rd;

    typedef struct {
        logic [2:0]      f;
        logic [ID_W-1:0] id;
        logic [31:0]     x;
        logic [31:0]     data;
        logic            err;
    } vec_t;
    vec_t v[6];

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic void ref_fn(input logic [2:0] f, input logic [31:0] x,
                                   output logic [31:0] d, output logic e);
        e = 1'b0;
        case (f)
            3'd0: d = ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
            3'd1: d = ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
            3'd2: d = ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
            3'd3: d = ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
            default: begin d = 32'd0; e = 1'b1; end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive at negedge, sample/check 1ns later, update model at posedge.
    task automatic step(input logic rv, input logic [ID_W-1:0] id, input logic [2:0] f,
                        input logic [31:0] x, input logic rr, input logic r);
        logic exp_rv, pop, exp_rdy;
        logic [31:0] d;
        logic e;
        exp_t ent;
        @(negedge clk);
        req_valid = rv; req_id = id; req_func = f; req_data0 = x;
        resp_ready = rr; rst = r;
        #1;
        s_rqr = req_ready; s_rv = resp_valid; s_rid = resp_id;
        s_rd = resp_data; s_re = resp_error;
        exp_rv = 1'b0; pop = 1'b0; exp_rdy = 1'b0;
        if (!r) begin
            exp_rv  = (q.size() > 0) && (cyc >= q[0].acc + 2);
            pop     = exp_rv && rr;
            exp_rdy = (q.size() - (pop ? 1 : 0)) < DEPTH;
            chk("resp_valid", 32'(s_rv), 32'(exp_rv));
            chk("req_ready", 32'(s_rqr), 32'(exp_rdy));
            if (exp_rv) begin
                chk("resp_id", 32'(s_rid), 32'(q[0].id));
                chk("resp_data", s_rd, q[0].data);
                chk("resp_error", 32'(s_re), 32'(q[0].err));
            end
        end
        last_fire = rv && exp_rdy && !r;
        @(posedge clk);
        if (r) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (last_fire) begin
                ref_fn(f, x, d, e);
                ent.id = id; ent.data = d; ent.err = e; ent.acc = cyc;
                q.push_back(ent);
            end
        end
        cyc++;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, '0, 3'd0, 32'd0, rr, 1'b0);
    endtask

    initial begin
        int idx, n;
        logic [31:0] bx[4];

        v[0] = '{3'd0, 4'd3, 32'h6a09e667, 32'hce20b47e, 1'b0};
        v[1] = '{3'd1, 4'd1, 32'h510e527f, 32'h3587272b, 1'b0};
        v[2] = '{3'd2, 4'd2, 32'h00000001, 32'h02004000, 1'b0};
        v[3] = '{3'd3, 4'd4, 32'h00000001, 32'h0000a000, 1'b0};
        v[4] = '{3'd5, 4'd7, 32'hffffffff, 32'h00000000, 1'b1};
        v[5] = '{3'd2, 4'd9, 32'h80000000, 32'h11002000, 1'b0};

        req_valid = 0; req_id = 0; req_func = 0; req_data0 = 0; resp_ready = 0; rst = 1;
        step(1'b0, '0, 3'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, '0, 3'd0, 32'd0, 1'b0, 1'b1);

        // reset state
        idle(1'b0);
        chk("reset_req_ready", 32'(s_rqr), 32'd1);
        chk("reset_resp_valid", 32'(s_rv), 32'd0);
        chk("reset_resp_id", 32'(s_rid), 32'd0);
        chk("reset_resp_data", s_rd, 32'd0);
        chk("reset_resp_error", 32'(s_re), 32'd0);

        // single op, two-cycle latency
        step(1'b1, v[0].id, v[0].f, v[0].x, 1'b1, 1'b0);
        idle(1'b1);
        chk("lat_not_yet", 32'(s_rv), 32'd0);
        idle(1'b1);
        chk("lat_valid", 32'(s_rv), 32'd1);
        chk("lat_data", s_rd, v[0].data);
        chk("lat_id", 32'(s_rid), 32'(v[0].id));

        // back-to-back table, resp_ready held high
        for (int k = 0; k < 8; k++) begin
            if (k < 6) step(1'b1, v[k].id, v[k].f, v[k].x, 1'b1, 1'b0);
            else idle(1'b1);
            if (k < 6) chk("b2b_ready", 32'(s_rqr), 32'd1);
            if (k >= 2) begin
                chk("tbl_valid", 32'(s_rv), 32'd1);
                chk("tbl_id", 32'(s_rid), 32'(v[k-2].id));
                chk("tbl_data", s_rd, v[k-2].data);
                chk("tbl_error", 32'(s_re), 32'(v[k-2].err));
            end
        end
        idle(1'b1);

        // backpressure: 4 offered with resp_ready low, only DEPTH accepted
        for (int i = 0; i < 4; i++) bx[i] = $urandom;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'(10 + idx), 3'd1, bx[idx], 1'b0, 1'b0);
            if (s_rqr) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        // full buffer, S1 empty, pop this cycle: a slot is free
        step(1'b1, 4'(10 + idx), 3'd1, bx[idx], 1'b1, 1'b0);
        chk("full_pushpop_ready", 32'(s_rqr), 32'd1);
        if (s_rqr) idx++;
        n = 0;
        while ((idx < 4 || q.size() > 0) && n < 20) begin
            step(idx < 4, 4'(10 + (idx & 3)), 3'd1, bx[idx & 3], 1'b1, 1'b0);
            if (idx < 4 && s_rqr) idx++;
            n++;
        end
        chk("bp_drain_done", 32'(q.size()), 32'd0);

        // reset with S1 and buffer occupied
        step(1'b1, 4'd5, 3'd0, 32'h12345678, 1'b0, 1'b0);
        step(1'b1, 4'd6, 3'd3, 32'h9abcdef0, 1'b0, 1'b0);
        step(1'b0, '0, 3'd0, 32'd0, 1'b0, 1'b1);
        idle(1'b1);
        chk("rstmid_resp_valid", 32'(s_rv), 32'd0);
        chk("rstmid_req_ready", 32'(s_rqr), 32'd1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // random traffic against the model
        idx = 0; n = 0;
        while (idx < 100 && n < 2000) begin
            step($urandom_range(0, 3) != 0, 4'($urandom), 3'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 3) != 0, 1'b0);
            if (last_fire) idx++;
            n++;
        end
        chk("rand_ops_issued", 32'(idx), 32'd100);
        n = 0;
        while (q.size() > 0 && n < 20) begin idle(1'b1); n++; end
        chk("rand_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
